// File: rtl/menu_nav_controller.sv
// Menu page sequencer: key edge detection, page FSM, countdown timer and game start strobes.
// Optional held up/down auto-repeat is compiled in when MENU_AUTOREPEAT_EN is defined.
module menu_nav_controller #(
  parameter int unsigned COUNT_TICKS   = 65_000_000,
  parameter int unsigned REPEAT_DELAY  = 32_500_000,
  parameter int unsigned REPEAT_PERIOD = 9_750_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keyboard_in,
  input  logic       back_to_main_menu_flag,
  output logic [2:0] menu_state,
  output logic [1:0] menu_counter,
  output logic       option_bit,
  output logic       start_game,
  output logic       start_pulse
);

  localparam int unsigned TickW = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;

  typedef enum logic [2:0] {
    StMain      = 3'd0,
    StOptions   = 3'd1,
    StCredits   = 3'd2,
    StCountdown = 3'd3,
    StGame      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ctr_q, ctr_d;
  logic             option_q, option_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [3:0]       k1_q, k2_q;
  logic [3:0]       press, press_eff;
  logic             start_game_q, start_game_d;
  logic             start_pulse_q, start_pulse_d;
  logic             key_up, key_down, key_enter, key_esc;
  logic             tick_expired;

  assign press        = k1_q & ~k2_q;
  assign tick_expired = (tick_q == TickW'(COUNT_TICKS - 1));

`ifdef MENU_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(REPEAT_DELAY + 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             hold_active, repeat_fire;

  // A lone up or down held steady on a navigable page re-issues its press.
  always_comb begin
    hold_active = (k1_q == k2_q) && ((k1_q == 4'b0001) || (k1_q == 4'b0010)) &&
                  ((state_q == StMain) || (state_q == StOptions));
    repeat_fire = hold_active && (hold_q == HoldW'(REPEAT_DELAY - 1));
    press_eff   = press | (repeat_fire ? k1_q : 4'b0000);
  end

  always_comb begin
    hold_d = '0;
    if (hold_active && (state_d == state_q)) begin
      hold_d = repeat_fire ? HoldW'(REPEAT_DELAY - REPEAT_PERIOD) : hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign press_eff = press;
`endif

  // Priority decode: esc > enter > a single up/down.
  assign key_esc   = press_eff[3];
  assign key_enter = press_eff[2] & ~key_esc;
  assign key_up    = press_eff[0] & ~press_eff[1] & ~key_esc & ~key_enter;
  assign key_down  = press_eff[1] & ~press_eff[0] & ~key_esc & ~key_enter;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StMain;
      ctr_q         <= 2'd0;
      option_q      <= 1'b0;
      tick_q        <= '0;
      k1_q          <= 4'b0000;
      k2_q          <= 4'b0000;
      start_game_q  <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      option_q      <= option_d;
      tick_q        <= tick_d;
      k1_q          <= keyboard_in;
      k2_q          <= k1_q;
      start_game_q  <= start_game_d;
      start_pulse_q <= start_pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    option_d = option_q;
    tick_d   = '0;
    unique case (state_q)
      StMain: begin
        if (key_enter) begin
          case (ctr_q)
            2'd0: begin
              state_d = StCountdown;
              ctr_d   = 2'd3;
            end
            2'd1: begin
              state_d = StOptions;
              ctr_d   = 2'd0;
            end
            2'd2: begin
              state_d = StCredits;
              ctr_d   = 2'd0;
            end
            default: ctr_d = 2'd0;
          endcase
        end else if (key_up) begin
          ctr_d = (ctr_q == 2'd0) ? 2'd2 : ctr_q - 2'd1;
        end else if (key_down) begin
          ctr_d = (ctr_q >= 2'd2) ? 2'd0 : ctr_q + 2'd1;
        end
      end
      StOptions: begin
        if (key_esc || (key_enter && (ctr_q != 2'd0))) begin
          state_d = StMain;
          ctr_d   = 2'd1;
        end else if (key_enter) begin
          option_d = ~option_q;
        end else if (key_up || key_down) begin
          ctr_d = {1'b0, ~ctr_q[0]};
        end
      end
      StCredits: begin
        if (key_esc || key_enter) begin
          state_d = StMain;
          ctr_d   = 2'd2;
        end
      end
      StCountdown: begin
        tick_d = tick_expired ? '0 : tick_q + TickW'(1);
        if (back_to_main_menu_flag || key_esc) begin
          state_d = StMain;
          ctr_d   = 2'd0;
          tick_d  = '0;
        end else if (tick_expired) begin
          if (ctr_q == 2'd0) begin
            state_d = StGame;
          end else begin
            ctr_d = ctr_q - 2'd1;
          end
        end
      end
      StGame: begin
        if (back_to_main_menu_flag) begin
          state_d = StMain;
          ctr_d   = 2'd0;
        end
      end
      default: begin
        state_d = StMain;
        ctr_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    start_game_d  = (state_d == StGame);
    start_pulse_d = (state_d == StGame) && (state_q != StGame);
  end

  assign menu_state   = state_q;
  assign menu_counter = ctr_q;
  assign option_bit   = option_q;
  assign start_game   = start_game_q;
  assign start_pulse  = start_pulse_q;

endmodule

// File: tb/tb_menu_nav_controller.sv
// Self-checking bench for menu_nav_controller: directed scenarios plus randomized key traffic
// compared every cycle against a page-level reference model.
module tb_menu_nav_controller;

  localparam int unsigned CT = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;

  logic       clk;
  logic       rst;
  logic [3:0] keyboard_in;
  logic       back_to_main_menu_flag;
  logic [2:0] menu_state;
  logic [1:0] menu_counter;
  logic       option_bit;
  logic       start_game;
  logic       start_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int         m_state, m_ctr, m_opt, m_game, m_pulse, m_cd, m_age;
  logic [3:0] s1, s2;

  menu_nav_controller #(
    .COUNT_TICKS  (CT),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .keyboard_in           (keyboard_in),
    .back_to_main_menu_flag(back_to_main_menu_flag),
    .menu_state            (menu_state),
    .menu_counter          (menu_counter),
    .option_bit            (option_bit),
    .start_game            (start_game),
    .start_pulse           (start_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ctr = 0; m_opt = 0; m_game = 0; m_pulse = 0; m_cd = 0; m_age = 0;
    s1 = 4'b0000; s2 = 4'b0000;
  endtask

  // Page-level behaviour for one clock edge; presses are rising edges of the sampled keys.
  task automatic model_edge(input logic [3:0] kb, input logic flag);
    logic [3:0] pr;
    int         prev;
    pr   = s1 & ~s2;
    prev = m_state;
`ifdef MENU_AUTOREPEAT_EN
    if ((s1 == s2) && (s1 == 4'b0001 || s1 == 4'b0010) && m_state <= 1) begin
      m_age++;
      if (m_age >= RD && ((m_age - RD) % RP) == 0) pr = s1;
    end else begin
      m_age = 0;
    end
`endif
    m_pulse = 0;
    if (flag && m_state >= 3) begin
      m_state = 0; m_ctr = 0;
    end else begin
      case (m_state)
        0: if (!pr[3]) begin
          if (pr[2]) begin
            if (m_ctr == 0) begin m_state = 3; m_ctr = 3; end
            else if (m_ctr == 1) begin m_state = 1; m_ctr = 0; end
            else begin m_state = 2; m_ctr = 0; end
          end else if (pr[0] && !pr[1]) m_ctr = (m_ctr + 2) % 3;
          else if (pr[1] && !pr[0]) m_ctr = (m_ctr + 1) % 3;
        end
        1: if (pr[3]) begin m_state = 0; m_ctr = 1; end
          else if (pr[2]) begin
            if (m_ctr == 0) m_opt = 1 - m_opt;
            else begin m_state = 0; m_ctr = 1; end
          end else if (pr[0] ^ pr[1]) m_ctr = 1 - m_ctr;
        2: if (pr[3] || pr[2]) begin m_state = 0; m_ctr = 2; end
        3: if (pr[3]) begin m_state = 0; m_ctr = 0; end
          else begin
            m_cd++;
            if (m_cd == 4 * CT) begin m_state = 4; m_ctr = 0; m_pulse = 1; end
            else m_ctr = 3 - m_cd / CT;
          end
        default: ;
      endcase
    end
    if (m_state != prev) m_age = 0;
    if (m_state == 3 && prev != 3) m_cd = 0;
    m_game = (m_state == 4) ? 1 : 0;
    s2 = s1;
    s1 = kb;
  endtask

  task automatic step(input logic [3:0] kb, input logic flag);
    keyboard_in = kb;
    back_to_main_menu_flag = flag;
    model_edge(kb, flag);
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("state@%0d", cyc), 8'(menu_state), 8'(m_state));
    check($sformatf("ctr@%0d", cyc), 8'(menu_counter), 8'(m_ctr));
    check($sformatf("opt@%0d", cyc), 8'(option_bit), 8'(m_opt));
    check($sformatf("game@%0d", cyc), 8'(start_game), 8'(m_game));
    check($sformatf("pulse@%0d", cyc), 8'(start_pulse), 8'(m_pulse));
  endtask

  task automatic press_key(input logic [3:0] kb);
    step(kb, 1'b0);
    step(4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    keyboard_in = 4'b0000;
    back_to_main_menu_flag = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] seq_key [5];
    int         seq_ctr [5];
    logic [3:0] kb, prev_kb;
    logic       fl;

    do_reset();
    check("reset_state", 8'(menu_state), 8'd0);
    check("reset_ctr", 8'(menu_counter), 8'd0);
    check("reset_opt", 8'(option_bit), 8'd0);
    check("reset_game", 8'(start_game), 8'd0);
    check("reset_pulse", 8'(start_pulse), 8'd0);

    // Navigation in MAIN with wrap; change visible one edge after E0.
    seq_key = '{4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    seq_ctr = '{1, 2, 1, 0, 2};
    for (int i = 0; i < 5; i++) begin
      step(seq_key[i], 1'b0);
      check($sformatf("nav_e0_%0d", i), 8'(menu_counter), 8'((i == 0) ? 0 : seq_ctr[i-1]));
      repeat (4) step(seq_key[i], 1'b0);
      check($sformatf("nav_%0d", i), 8'(menu_counter), 8'(seq_ctr[i]));
      repeat (2) step(4'b0000, 1'b0);
    end

    // Countdown into GAME.
    press_key(4'b0010);
    press_key(4'b0100);
    check("cd_state", 8'(menu_state), 8'd3);
    check("cd_ctr", 8'(menu_counter), 8'd3);
    repeat (4) step(4'b0000, 1'b0);
    check("cd_ctr2", 8'(menu_counter), 8'd2);
    repeat (11) step(4'b0000, 1'b0);
    check("cd_ctr0", 8'(menu_counter), 8'd0);
    step(4'b0000, 1'b0);
    check("game_state", 8'(menu_state), 8'd4);
    check("game_pulse", 8'(start_pulse), 8'd1);
    step(4'b0000, 1'b0);
    check("game_pulse_off", 8'(start_pulse), 8'd0);
    check("game_level", 8'(start_game), 8'd1);

    // Keys ignored in GAME; flag returns to MAIN.
    press_key(4'b1000);
    press_key(4'b0100);
    check("game_keys", 8'(menu_state), 8'd4);
    step(4'b0000, 1'b1);
    check("flag_state", 8'(menu_state), 8'd0);
    check("flag_game", 8'(start_game), 8'd0);
    step(4'b0000, 1'b0);

    // Options page and toggle.
    press_key(4'b0010);
    press_key(4'b0100);
    check("opt_enter", 8'(menu_state), 8'd1);
    press_key(4'b0100);
    check("opt_toggle", 8'(option_bit), 8'd1);
    press_key(4'b0010);
    press_key(4'b0100);
    check("opt_back_state", 8'(menu_state), 8'd0);
    check("opt_back_ctr", 8'(menu_counter), 8'd1);

    // Simultaneous presses.
    press_key(4'b0100);
    press_key(4'b1100);
    check("esc_wins_state", 8'(menu_state), 8'd0);
    check("esc_wins_ctr", 8'(menu_counter), 8'd1);
    press_key(4'b0011);
    check("updown_none", 8'(menu_counter), 8'd1);

    // Credits page.
    press_key(4'b0010);
    press_key(4'b0100);
    check("credits", 8'(menu_state), 8'd2);
    press_key(4'b0001);
    press_key(4'b1000);
    check("credits_back", 8'(menu_counter), 8'd2);

    // Long hold of down in MAIN.
    repeat (20) step(4'b0010, 1'b0);
`ifdef MENU_AUTOREPEAT_EN
    check("hold_ctr", 8'(menu_counter), 8'd1);
`else
    check("hold_ctr", 8'(menu_counter), 8'd0);
`endif
    repeat (2) step(4'b0000, 1'b0);

    // Randomized traffic; holds stay short of the auto-repeat delay.
    prev_kb = 4'b0000;
    for (int n = 0; n < 150; n++) begin
      do kb = 4'($urandom_range(0, 15)); while (kb == prev_kb);
      if ($urandom_range(0, 2) == 0) kb = kb & 4'b0100;
      if (kb == prev_kb) kb = 4'b0000;
      if (kb == prev_kb) kb = 4'b0001;
      prev_kb = kb;
      fl = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 3)) step(kb, fl);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) step(4'b0000, 1'b0);
    end

    // Asynchronous reset mid-countdown.
    do_reset();
    press_key(4'b0100);
    repeat (5) step(4'b0000, 1'b0);
    check("pre_rst_state", 8'(menu_state), 8'd3);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", 8'(menu_state), 8'd0);
    check("async_rst_ctr", 8'(menu_counter), 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step(4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
